// File: rtl/led_pulse_stretcher_if.sv
// Event strobe and LED status bundle for led_pulse_stretcher.
// master = event source / status reader, slave = the stretcher.
interface led_pulse_stretcher_if #(
    parameter int PEND_WIDTH = 4
);
    logic                  i_Event;
    logic                  i_Clr_Ovf;
    logic                  o_Led;
    logic                  o_Busy;
    logic [PEND_WIDTH-1:0] o_Pending;
    logic                  o_Overflow;

    modport master (
        output i_Event,
        output i_Clr_Ovf,
        input  o_Led,
        input  o_Busy,
        input  o_Pending,
        input  o_Overflow
    );

    modport slave (
        input  i_Event,
        input  i_Clr_Ovf,
        output o_Led,
        output o_Busy,
        output o_Pending,
        output o_Overflow
    );
endinterface

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle events into ON/GAP LED blinks,
// queueing events that arrive while a blink is in progress.
module led_pulse_stretcher #(
    parameter int ON_CYCLES  = 100000,
    parameter int GAP_CYCLES = 100000,
    parameter int PEND_WIDTH = 4
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    led_pulse_stretcher_if.slave bus
);
    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0]         ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]         GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [PEND_WIDTH-1:0] pend, pend_nxt;
    logic                  led, busy, ovf;
    logic                  on_last, gap_last;
    logic                  direct, dec, want_inc, inc, drop;

    always_comb begin
        on_last  = (state == S_ON) && (timer == ON_LAST);
        gap_last = (state == S_GAP) && (timer == GAP_LAST);
        dec      = gap_last && (pend != '0);
        direct   = bus.i_Event &&
                   ((state == S_IDLE) || (gap_last && (pend == '0)));
        want_inc = bus.i_Event && !direct;
        // a decrement in the same cycle frees the slot for a saturated queue
        inc      = want_inc && ((pend != PEND_MAX) || dec);
        drop     = want_inc && (pend == PEND_MAX) && !dec;
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        unique case (1'b1)
            (state == S_ON): begin
                if (on_last) begin
                    state_nxt = S_GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            (state == S_GAP): begin
                if (gap_last) begin
                    state_nxt = (dec || direct) ? S_ON : S_IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = direct ? S_ON : S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        pend_nxt = pend;
        if (inc && !dec)
            pend_nxt = pend + 1'b1;
        else if (dec && !inc)
            pend_nxt = pend - 1'b1;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= S_IDLE;
            timer <= '0;
            pend  <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            pend  <= pend_nxt;
            led   <= (state_nxt == S_ON);
            busy  <= (state_nxt != S_IDLE);
            // a lost event outranks a clear in the same cycle
            if (drop)
                ovf <= 1'b1;
            else if (bus.i_Clr_Ovf)
                ovf <= 1'b0;
        end
    end

    assign bus.o_Led      = led;
    assign bus.o_Busy     = busy;
    assign bus.o_Pending  = pend;
    assign bus.o_Overflow = ovf;
endmodule
